// File: rtl/dx_operand_stage.sv
// dx_operand_stage: D/X pipeline latch plus operand-bypass front end for the
// execute-stage ALU. Latches the decoded instruction, PC and regfile data, then
// resolves ALU operands, opcode and shift amount from the latched instruction.
// Inserts one bubble into X when the instruction in D must wait for a producer.
//
// Build option: define DX_FORWARD_EN to enable the X/M and M/W bypass network.
// In that build only load-use hazards stall. Without it, operands always come
// from the latch, and any RAW hazard against X, X/M or M/W stalls D.
//
// There is no sequencing FSM in this block, so there is no state table. The
// only state is the X latch: a valid instruction or a bubble.

module dx_operand_stage (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        d_valid,
   input  logic [31:0] d_insn,
   input  logic [31:0] d_pc,
   input  logic [31:0] d_regA,
   input  logic [31:0] d_regB,
   input  logic        xm_valid,
   input  logic [31:0] xm_insn,
   input  logic [31:0] xm_result,
   input  logic        mw_valid,
   input  logic [31:0] mw_insn,
   input  logic [31:0] mw_data,
   output logic        x_valid,
   output logic [31:0] x_insn,
   output logic [31:0] x_pc,
   output logic [31:0] x_operandA,
   output logic [31:0] x_operandB,
   output logic [31:0] x_store_data,
   output logic [4:0]  x_aluop,
   output logic [4:0]  x_shamt,
   output logic        load_use_stall
);

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_BNE   = 5'b00010;
   localparam logic [4:0] OP_JAL   = 5'b00011;
   localparam logic [4:0] OP_JR    = 5'b00100;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_BLT   = 5'b00110;
   localparam logic [4:0] OP_SW    = 5'b00111;
   localparam logic [4:0] OP_LW    = 5'b01000;
   localparam logic [4:0] OP_SETX  = 5'b10101;
   localparam logic [4:0] OP_BEX   = 5'b10110;

   // A source index of 0 means "no source"; r0 reads as zero anyway.
   function automatic logic [4:0] src_a(input logic [31:0] insn);
      case (insn[31:27])
         OP_RTYPE, OP_ADDI, OP_LW, OP_SW: src_a = insn[21:17];
         OP_BNE, OP_BLT, OP_JR:           src_a = insn[26:22];
         OP_BEX:                          src_a = 5'd30;
         default:                         src_a = 5'd0;
      endcase
   endfunction

   function automatic logic [4:0] src_b(input logic [31:0] insn);
      case (insn[31:27])
         OP_RTYPE:       src_b = insn[16:12];
         OP_BNE, OP_BLT: src_b = insn[21:17];
         default:        src_b = 5'd0;
      endcase
   endfunction

   function automatic logic [4:0] src_st(input logic [31:0] insn);
      src_st = (insn[31:27] == OP_SW) ? insn[26:22] : 5'd0;
   endfunction

   // Overflow writes to r30 are not predicted; they show up later via M/W.
   function automatic logic [4:0] dest_of(input logic [31:0] insn);
      case (insn[31:27])
         OP_RTYPE, OP_ADDI, OP_LW: dest_of = insn[26:22];
         OP_JAL:                   dest_of = 5'd31;
         OP_SETX:                  dest_of = 5'd30;
         default:                  dest_of = 5'd0;
      endcase
   endfunction

   function automatic logic b_is_imm(input logic [31:0] insn);
      b_is_imm = (insn[31:27] == OP_ADDI) || (insn[31:27] == OP_LW) ||
                 (insn[31:27] == OP_SW);
   endfunction

`ifdef DX_FORWARD_EN
   // X/M wins over M/W. A load in X/M has no data yet, so it never forwards.
   function automatic logic [31:0] read_src(input logic [4:0]  src,
                                            input logic [31:0] latched,
                                            input logic        xm_ok,
                                            input logic [4:0]  xm_dst,
                                            input logic [31:0] xm_val,
                                            input logic        mw_ok,
                                            input logic [4:0]  mw_dst,
                                            input logic [31:0] mw_val);
      if (src == 5'd0)                     read_src = 32'd0;
      else if (xm_ok && (xm_dst == src))   read_src = xm_val;
      else if (mw_ok && (mw_dst == src))   read_src = mw_val;
      else                                 read_src = latched;
   endfunction
`else
   function automatic logic [31:0] read_src(input logic [4:0]  src,
                                            input logic [31:0] latched);
      read_src = (src == 5'd0) ? 32'd0 : latched;
   endfunction

   // Forwarded data is not consumed without the bypass network.
   logic unused_fwd_data;
   assign unused_fwd_data = ^{xm_result, mw_data};
`endif

   logic        x_valid_q, x_valid_d;
   logic [31:0] x_insn_q,  x_insn_d;
   logic [31:0] x_pc_q,    x_pc_d;
   logic [31:0] x_rega_q,  x_rega_d;
   logic [31:0] x_regb_q,  x_regb_d;

   logic [4:0]  d_sa, d_sb, d_ss;
   logic        hazard;

   // Hazard detection for the instruction waiting in D.
   always_comb begin
      d_sa   = src_a(d_insn);
      d_sb   = src_b(d_insn);
      d_ss   = src_st(d_insn);
      hazard = 1'b0;
`ifdef DX_FORWARD_EN
      if (x_valid_q && (x_insn_q[31:27] == OP_LW) && (x_insn_q[26:22] != 5'd0) &&
          ((x_insn_q[26:22] == d_sa) || (x_insn_q[26:22] == d_sb) ||
           (x_insn_q[26:22] == d_ss)))
         hazard = 1'b1;
`else
      for (int k = 0; k < 3; k++) begin
         logic [4:0] s;
         s = (k == 0) ? d_sa : ((k == 1) ? d_sb : d_ss);
         if ((s != 5'd0) &&
             ((x_valid_q && (dest_of(x_insn_q) == s)) ||
              (xm_valid  && (dest_of(xm_insn)  == s)) ||
              (mw_valid  && (dest_of(mw_insn)  == s))))
            hazard = 1'b1;
      end
`endif
      load_use_stall = d_valid && hazard;
   end

   // Next X latch contents: flush, then hold, then bubble, then capture.
   always_comb begin
      x_valid_d = x_valid_q;
      x_insn_d  = x_insn_q;
      x_pc_d    = x_pc_q;
      x_rega_d  = x_rega_q;
      x_regb_d  = x_regb_q;
      if (flush || (!stall && load_use_stall)) begin
         x_valid_d = 1'b0;
         x_insn_d  = 32'd0;
         x_pc_d    = 32'd0;
         x_rega_d  = 32'd0;
         x_regb_d  = 32'd0;
      end else if (!stall) begin
         x_valid_d = d_valid;
         x_insn_d  = d_insn;
         x_pc_d    = d_pc;
         x_rega_d  = d_regA;
         x_regb_d  = d_regB;
      end
   end

   // X latch with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         x_valid_q <= 1'b0;
         x_insn_q  <= 32'd0;
         x_pc_q    <= 32'd0;
         x_rega_q  <= 32'd0;
         x_regb_q  <= 32'd0;
      end else begin
         x_valid_q <= x_valid_d;
         x_insn_q  <= x_insn_d;
         x_pc_q    <= x_pc_d;
         x_rega_q  <= x_rega_d;
         x_regb_q  <= x_regb_d;
      end
   end

   // Operand selection and ALU control from the latched instruction.
   always_comb begin
      logic [4:0]  op;
      logic [31:0] imm_sext;
`ifdef DX_FORWARD_EN
      logic        xm_ok, mw_ok;
      logic [4:0]  xm_dst, mw_dst;
      xm_ok  = xm_valid && (xm_insn[31:27] != OP_LW);
      mw_ok  = mw_valid;
      xm_dst = dest_of(xm_insn);
      mw_dst = dest_of(mw_insn);
`endif
      op       = x_insn_q[31:27];
      imm_sext = {{15{x_insn_q[16]}}, x_insn_q[16:0]};
`ifdef DX_FORWARD_EN
      x_operandA   = read_src(src_a(x_insn_q), x_rega_q,
                              xm_ok, xm_dst, xm_result, mw_ok, mw_dst, mw_data);
      x_operandB   = b_is_imm(x_insn_q) ? imm_sext :
                     read_src(src_b(x_insn_q), x_regb_q,
                              xm_ok, xm_dst, xm_result, mw_ok, mw_dst, mw_data);
      x_store_data = read_src(src_st(x_insn_q), x_regb_q,
                              xm_ok, xm_dst, xm_result, mw_ok, mw_dst, mw_data);
`else
      x_operandA   = read_src(src_a(x_insn_q), x_rega_q);
      x_operandB   = b_is_imm(x_insn_q) ? imm_sext :
                     read_src(src_b(x_insn_q), x_regb_q);
      x_store_data = read_src(src_st(x_insn_q), x_regb_q);
`endif
      if (op == OP_RTYPE)                        x_aluop = x_insn_q[6:2];
      else if ((op == OP_BNE) || (op == OP_BLT)) x_aluop = 5'b00001;
      else                                       x_aluop = 5'b00000;
      x_shamt = (op == OP_RTYPE) ? x_insn_q[11:7] : 5'd0;
   end

   assign x_valid = x_valid_q;
   assign x_insn  = x_insn_q;
   assign x_pc    = x_pc_q;

endmodule

// File: tb/tb_dx_operand_stage.sv
// Testbench for dx_operand_stage: directed vector table, hand-written
// multi-cycle sequences, then random traffic against a reference model.
module tb_dx_operand_stage;

   logic        clock = 1'b0;
   logic        reset, stall, flush, d_valid;
   logic [31:0] d_insn, d_pc, d_regA, d_regB;
   logic        xm_valid, mw_valid;
   logic [31:0] xm_insn, xm_result, mw_insn, mw_data;
   logic        x_valid, load_use_stall;
   logic [31:0] x_insn, x_pc, x_operandA, x_operandB, x_store_data;
   logic [4:0]  x_aluop, x_shamt;

   int n_vec = 0;
   int n_err = 0;

   dx_operand_stage dut (
      .clock(clock), .reset(reset), .stall(stall), .flush(flush),
      .d_valid(d_valid), .d_insn(d_insn), .d_pc(d_pc), .d_regA(d_regA), .d_regB(d_regB),
      .xm_valid(xm_valid), .xm_insn(xm_insn), .xm_result(xm_result),
      .mw_valid(mw_valid), .mw_insn(mw_insn), .mw_data(mw_data),
      .x_valid(x_valid), .x_insn(x_insn), .x_pc(x_pc),
      .x_operandA(x_operandA), .x_operandB(x_operandB), .x_store_data(x_store_data),
      .x_aluop(x_aluop), .x_shamt(x_shamt), .load_use_stall(load_use_stall)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      reset = 0; stall = 0; flush = 0; d_valid = 0;
      d_insn = 0; d_pc = 0; d_regA = 0; d_regB = 0;
      xm_valid = 0; xm_insn = 0; xm_result = 0;
      mw_valid = 0; mw_insn = 0; mw_data = 0;
   endtask

   function automatic logic [31:0] enc_r(input logic [4:0] rd, rs, rt, sh, alu);
      return {5'd0, rd, rs, rt, sh, alu, 2'b00};
   endfunction

   function automatic logic [31:0] enc_i(input logic [4:0] op, rd, rs, input logic [16:0] imm);
      return {op, rd, rs, imm};
   endfunction

   // ---------------- reference model ----------------
   // Which architectural register each operand role reads (0 = none).
   function automatic logic [4:0] m_src(input logic [31:0] i, input int role);
      int op;
      op = int'(i[31:27]);
      case (role)
         0: begin
            if (op == 0 || op == 5 || op == 8 || op == 7) return i[21:17];
            if (op == 2 || op == 6 || op == 4)            return i[26:22];
            if (op == 22)                                 return 5'd30;
            return 5'd0;
         end
         1: begin
            if (op == 0)            return i[16:12];
            if (op == 2 || op == 6) return i[21:17];
            return 5'd0;
         end
         default: return (op == 7) ? i[26:22] : 5'd0;
      endcase
   endfunction

   function automatic logic [4:0] m_dest(input logic [31:0] i);
      int op;
      op = int'(i[31:27]);
      if (op == 0 || op == 5 || op == 8) return i[26:22];
      if (op == 3)  return 5'd31;
      if (op == 21) return 5'd30;
      return 5'd0;
   endfunction

   // Architectural value of a register as seen by X: newest producer first.
   function automatic logic [31:0] m_read(input logic [4:0] r, input logic [31:0] latched);
      if (r == 0) return 32'd0;
`ifdef DX_FORWARD_EN
      if (xm_valid && m_dest(xm_insn) == r && xm_insn[31:27] != 5'd8) return xm_result;
      if (mw_valid && m_dest(mw_insn) == r) return mw_data;
`endif
      return latched;
   endfunction

   logic        m_valid;
   logic [31:0] m_insn, m_pc, m_ra, m_rb;

   function automatic logic m_lus();
      if (!d_valid) return 1'b0;
`ifdef DX_FORWARD_EN
      if (!(m_valid && m_insn[31:27] == 5'd8 && m_insn[26:22] != 0)) return 1'b0;
      for (int k = 0; k < 3; k++)
         if (m_src(d_insn, k) == m_insn[26:22]) return 1'b1;
      return 1'b0;
`else
      for (int k = 0; k < 3; k++) begin
         logic [4:0] s;
         s = m_src(d_insn, k);
         if (s != 0 && ((m_valid && m_dest(m_insn) == s) ||
                        (xm_valid && m_dest(xm_insn) == s) ||
                        (mw_valid && m_dest(mw_insn) == s)))
            return 1'b1;
      end
      return 1'b0;
`endif
   endfunction

   task automatic model_edge();
      logic lus;
      lus = m_lus();
      if (reset || flush || (!stall && lus)) begin
         m_valid = 0; m_insn = 0; m_pc = 0; m_ra = 0; m_rb = 0;
      end else if (!stall) begin
         m_valid = d_valid; m_insn = d_insn; m_pc = d_pc; m_ra = d_regA; m_rb = d_regB;
      end
   endtask

   task automatic model_check();
      int op;
      logic [31:0] eb;
      logic [4:0] eop;
      op = int'(m_insn[31:27]);
      if (op == 5 || op == 8 || op == 7) eb = {{15{m_insn[16]}}, m_insn[16:0]};
      else                               eb = m_read(m_src(m_insn, 1), m_rb);
      eop = (op == 0) ? m_insn[6:2] : ((op == 2 || op == 6) ? 5'd1 : 5'd0);
      chk("rnd_valid", {31'd0, x_valid}, {31'd0, m_valid});
      chk("rnd_insn", x_insn, m_insn);
      chk("rnd_pc", x_pc, m_pc);
      chk("rnd_opA", x_operandA, m_read(m_src(m_insn, 0), m_ra));
      chk("rnd_opB", x_operandB, eb);
      chk("rnd_store", x_store_data, m_read(m_src(m_insn, 2), m_rb));
      chk("rnd_aluop", {27'd0, x_aluop}, {27'd0, eop});
      chk("rnd_shamt", {27'd0, x_shamt}, (op == 0) ? {27'd0, m_insn[11:7]} : 32'd0);
      chk("rnd_lus", {31'd0, load_use_stall}, {31'd0, m_lus()});
   endtask

   function automatic logic [31:0] rand_insn();
      logic [4:0] ops [11];
      ops = '{5'd0, 5'd0, 5'd5, 5'd8, 5'd7, 5'd2, 5'd6, 5'd4, 5'd22, 5'd3, 5'd21};
      return {ops[$urandom_range(0, 10)], 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 12'($urandom)};
   endfunction

   // ---------------- directed vector table ----------------
   typedef struct {
      string       name;
      logic [31:0] insn, ra, rb;
      logic        xmv;
      logic [31:0] xmi, xmr;
      logic        mwv;
      logic [31:0] mwi, mwd;
      logic [31:0] ea_f, ea_n, eb_f, eb_n, es_f, es_n;
      logic [4:0]  eop, esh;
   } vec_t;

   vec_t vt[9];

   initial begin
      logic [31:0] held_insn, held_pc;
      int cyc;

      vt[0] = '{"xm_over_mw", enc_r(4, 3, 3, 0, 0), 32'h111, 32'h111,
                1, enc_r(3, 1, 2, 0, 0), 32'd5, 1, enc_r(3, 1, 1, 0, 0), 32'd9,
                32'd5, 32'h111, 32'd5, 32'h111, 0, 0, 5'd0, 5'd0};
      vt[1] = '{"r0_reads_zero", enc_r(5, 0, 0, 5'd7, 5'd3), 32'h55, 32'h55,
                1, enc_r(0, 1, 2, 0, 0), 32'd7, 1, enc_r(0, 1, 2, 0, 0), 32'd8,
                0, 0, 0, 0, 0, 0, 5'd3, 5'd7};
      vt[2] = '{"bne_ops", enc_i(2, 1, 2, 17'h00010), 32'hAAAA, 32'hBBBB,
                0, 0, 0, 0, 0, 0,
                32'hAAAA, 32'hAAAA, 32'hBBBB, 32'hBBBB, 0, 0, 5'd1, 5'd0};
      vt[3] = '{"sw_store_bypass", enc_i(7, 6, 7, 17'h00008), 32'h1000, 32'h66,
                1, enc_i(8, 6, 0, 0), 32'h99, 1, enc_r(6, 1, 1, 0, 0), 32'h77,
                32'h1000, 32'h1000, 32'd8, 32'd8, 32'h77, 32'h66, 5'd0, 5'd0};
      vt[4] = '{"addi_neg_imm_mw", enc_i(5, 5, 2, 17'h1FFFF), 32'h20, 0,
                0, 0, 0, 1, enc_i(8, 2, 0, 0), 32'h10,
                32'h10, 32'h20, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 5'd0, 5'd0};
      vt[5] = '{"jr_from_jal", enc_i(4, 31, 0, 0), 32'h300, 32'h3,
                1, enc_i(3, 0, 0, 17'h40), 32'h44, 0, 0, 0,
                32'h44, 32'h300, 0, 0, 0, 0, 5'd0, 5'd0};
      vt[6] = '{"bex_from_setx", enc_i(22, 0, 0, 17'h5), 32'hBE, 0,
                0, 0, 0, 1, enc_i(21, 0, 0, 17'h5), 32'd5,
                32'd5, 32'hBE, 0, 0, 0, 0, 5'd0, 5'd0};
      vt[7] = '{"rtype_no_valid_prod", enc_r(1, 2, 3, 5'd9, 5'd1), 32'd10, 32'd20,
                0, enc_r(3, 0, 0, 0, 0), 32'd99, 0, enc_r(2, 0, 0, 0, 0), 32'd98,
                32'd10, 32'd10, 32'd20, 32'd20, 0, 0, 5'd1, 5'd9};
      vt[8] = '{"lw_xm_not_fwd", enc_i(5, 1, 2, 17'h4), 32'h222, 0,
                1, enc_i(8, 2, 0, 0), 32'hDEAD, 1, enc_r(2, 0, 0, 0, 0), 32'h5,
                32'h5, 32'h222, 32'd4, 32'd4, 0, 0, 5'd0, 5'd0};

      idle_inputs();

      // reset held for two cycles
      reset = 1;
      tick(); tick();
      #2;
      chk("rst_valid", {31'd0, x_valid}, 32'd0);
      chk("rst_insn", x_insn, 32'd0);
      chk("rst_opA", x_operandA, 32'd0);
      chk("rst_opB", x_operandB, 32'd0);
      chk("rst_lus", {31'd0, load_use_stall}, 32'd0);
      reset = 0;

      foreach (vt[i]) begin
         idle_inputs();
         flush = 1;
         tick();
         idle_inputs();
         d_valid = 1; d_insn = vt[i].insn; d_regA = vt[i].ra; d_regB = vt[i].rb;
         d_pc = 32'h400 + 32'(i);
         tick();
         idle_inputs();
         xm_valid = vt[i].xmv; xm_insn = vt[i].xmi; xm_result = vt[i].xmr;
         mw_valid = vt[i].mwv; mw_insn = vt[i].mwi; mw_data = vt[i].mwd;
         #2;
`ifdef DX_FORWARD_EN
         chk({vt[i].name, "_A"}, x_operandA, vt[i].ea_f);
         chk({vt[i].name, "_B"}, x_operandB, vt[i].eb_f);
         chk({vt[i].name, "_st"}, x_store_data, vt[i].es_f);
`else
         chk({vt[i].name, "_A"}, x_operandA, vt[i].ea_n);
         chk({vt[i].name, "_B"}, x_operandB, vt[i].eb_n);
         chk({vt[i].name, "_st"}, x_store_data, vt[i].es_n);
`endif
         chk({vt[i].name, "_aluop"}, {27'd0, x_aluop}, {27'd0, vt[i].eop});
         chk({vt[i].name, "_shamt"}, {27'd0, x_shamt}, {27'd0, vt[i].esh});
         chk({vt[i].name, "_pc"}, x_pc, 32'h400 + 32'(i));
      end

      // stall holds X for three cycles, then flush beats stall
      idle_inputs();
      flush = 1; tick();
      idle_inputs();
      d_valid = 1; d_insn = enc_r(4, 1, 2, 0, 0); d_pc = 32'h800; d_regA = 1; d_regB = 2;
      tick();
      held_insn = enc_r(4, 1, 2, 0, 0); held_pc = 32'h800;
      stall = 1;
      for (int c = 0; c < 3; c++) begin
         d_insn = enc_r(5'(7 + c), 5, 6, 0, 0); d_pc = 32'h900 + 32'(c);
         tick();
         #1;
         chk("stall_hold_insn", x_insn, held_insn);
         chk("stall_hold_pc", x_pc, held_pc);
         chk("stall_hold_valid", {31'd0, x_valid}, 32'd1);
      end
      flush = 1;
      tick();
      #1;
      chk("flush_over_stall_valid", {31'd0, x_valid}, 32'd0);
      chk("flush_over_stall_insn", x_insn, 32'd0);
      idle_inputs();

`ifdef DX_FORWARD_EN
      // lw r2 in X, addi r5,r2,-1 in D: one bubble, then bypass from M/W
      d_valid = 1; d_insn = enc_i(8, 2, 3, 0); tick();
      d_insn = enc_i(5, 5, 2, 17'h1FFFF); d_regA = 32'hBAD;
      #1;
      chk("lu_stall_hi", {31'd0, load_use_stall}, 32'd1);
      tick();
      xm_valid = 1; xm_insn = enc_i(8, 2, 3, 0); xm_result = 32'hBEEF;
      #1;
      chk("lu_bubble", {31'd0, x_valid}, 32'd0);
      chk("lu_stall_lo", {31'd0, load_use_stall}, 32'd0);
      tick();
      xm_valid = 0; d_valid = 0;
      mw_valid = 1; mw_insn = enc_i(8, 2, 3, 0); mw_data = 32'h10;
      #1;
      chk("lu_opA", x_operandA, 32'h10);
      chk("lu_opB", x_operandB, 32'hFFFFFFFF);
      chk("lu_aluop", {27'd0, x_aluop}, 32'd0);
`else
      // add r1 in X, D reads r1: stalls while r1's producer is in X, X/M, M/W
      d_valid = 1; d_insn = enc_r(1, 2, 3, 0, 0); tick();
      d_insn = enc_r(2, 1, 0, 0, 0);
      cyc = 0;
      for (int c = 0; c < 6; c++) begin
         xm_valid = (c == 1); xm_insn = enc_r(1, 2, 3, 0, 0);
         mw_valid = (c == 2); mw_insn = enc_r(1, 2, 3, 0, 0);
         #1;
         if (load_use_stall) cyc++;
         else break;
         tick();
      end
      chk("raw_stall_cycles", 32'(cyc), 32'd3);
      tick();
      #1;
      chk("raw_dep_enters", x_insn, enc_r(2, 1, 0, 0, 0));
      chk("raw_dep_valid", {31'd0, x_valid}, 32'd1);
`endif

      // random traffic against the reference model
      idle_inputs();
      for (int n = 0; n < 400; n++) begin
         reset   = (n == 0) || ($urandom_range(0, 49) == 0);
         flush   = ($urandom_range(0, 9) == 0);
         stall   = ($urandom_range(0, 7) == 0);
         d_valid = ($urandom_range(0, 4) != 0);
         d_insn  = rand_insn(); d_pc = $urandom; d_regA = $urandom; d_regB = $urandom;
         xm_valid = $urandom_range(0, 1) == 1; xm_insn = rand_insn(); xm_result = $urandom;
         mw_valid = $urandom_range(0, 1) == 1; mw_insn = rand_insn(); mw_data = $urandom;
         #2;
         if (n > 0) model_check();
         model_edge();
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
